ram_initiator: RTL

- CPU-side master for the handshaked RAM port: read/write strobes, separate read/write address buses, and a wrdy/rrdy busy-then-ready handshake with an exc fault flag.
- Accepts one load/store request at a time on a valid/ready interface.
- Sequences the RAM handshake, then returns a one-cycle response carrying read data, the exception flag and a timeout flag.
- Sits between the CPU load/store path and ram / emb_ram-compatible memories.

---
 rtl/ram_initiator.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ram_initiator.sv
// ram_initiator
//   CPU-side master for a handshaked RAM port. Accepts one load/store at a
//   time on a valid/ready interface, drives the RAM read or write strobe
//   through a mandatory busy-then-ready handshake, and returns a one-cycle
//   response with read data, the RAM fault flag and a timeout flag.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   req_valid      request present
//   req_ready      initiator idle and able to accept a request
//   req_we         1 = store, 0 = load
//   req_addr       request address
//   req_wdata      store data
//   resp_valid     one-cycle response pulse
//   resp_rdata     load data (0 for stores and aborted transactions)
//   resp_exc       RAM fault or timeout
//   resp_timeout   transaction aborted by timeout
//   r_addr, read   RAM read address and strobe
//   w_addr, w_line RAM write address and data
//   write          RAM write strobe
//   r_line         RAM read data
//   rrdy, wrdy     RAM read/write ready (low = busy)
//   exc            RAM exception, sampled on the completing edge

module ram_initiator #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_exc,
    output logic          resp_timeout,
    output logic [AW-1:0] r_addr,
    output logic [AW-1:0] w_addr,
    output logic [DW-1:0] w_line,
    output logic          read,
    output logic          write,
    input  logic [DW-1:0] r_line,
    input  logic          rrdy,
    input  logic          wrdy,
    input  logic          exc
);

    // Counter holds up to TIMEOUT+1: a ready transition on the TIMEOUT edge
    // moves ISSUE to WAIT, and the abort then fires on the following edge.
    localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 2) : 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP,
        RECOVER
    } state_t;

    state_t        state;
    logic          we_q;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          sel_rdy;
    logic          timed_out;

    assign req_ready = (state == IDLE);
    assign sel_rdy   = we_q ? wrdy : rrdy;
    assign cnt_inc   = cnt + CW'(1);
    assign timed_out = (TIMEOUT > 0) && (cnt_inc >= TO_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            we_q         <= 1'b0;
            cnt          <= '0;
            read         <= 1'b0;
            write        <= 1'b0;
            r_addr       <= '0;
            w_addr       <= '0;
            w_line       <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_exc     <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q <= req_we;
                        if (req_we) begin
                            w_addr <= req_addr;
                            w_line <= req_wdata;
                            write  <= 1'b1;
                        end else begin
                            r_addr <= req_addr;
                            read   <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= ISSUE;
                    end
                end

                // Ready must be seen low before completion is possible;
                // a ready transition takes priority over the timeout.
                ISSUE: begin
                    cnt <= cnt_inc;
                    if (!sel_rdy) begin
                        state <= WAIT;
                    end else if (timed_out) begin
                        read         <= 1'b0;
                        write        <= 1'b0;
                        resp_timeout <= 1'b1;
                        resp_exc     <= 1'b1;
                        resp_rdata   <= '0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end
                end

                WAIT: begin
                    cnt <= cnt_inc;
                    if (sel_rdy) begin
                        read         <= 1'b0;
                        write        <= 1'b0;
                        resp_exc     <= exc;
                        resp_rdata   <= we_q ? '0 : r_line;
                        resp_timeout <= 1'b0;
                        resp_valid   <= 1'b1;
                        state        <= RESP;
                    end else if (timed_out) begin
                        read         <= 1'b0;
                        write        <= 1'b0;
                        resp_timeout <= 1'b1;
                        resp_exc     <= 1'b1;
                        resp_rdata   <= '0;
                        state        <= RECOVER;
                    end
                end

                // RAM is still busy with the abandoned access; wait for it to
                // finish before reporting, discarding whatever it returns.
                RECOVER: begin
                    if (sel_rdy) begin
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end

                RESP: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
